escalonador_paradas: RTL and testbench
======================================

// Module: escalonador_paradas
// PURPOSE
//  Cargo-elevator stop scheduler. Sits between the serial request decoder and the motor drivers.
//  Stores up to PROF_FILA transport requests (origin/dest/obj), tracks the car position from the
//  floor sensors and picks the next stop with SCAN order (keep direction while stops lie ahead).
//  Drives motor up/down, holds the door dwell at each stop and pulses one event per delivered object.
// PARAMETERS
//  N_ANDARES   4        number of floors; floor index width is LARG_ANDAR
//  LARG_ANDAR  2        floor index width, clog2(N_ANDARES)
//  PROF_FILA   16       request table slots
//  T_PORTA     2500000  dwell cycles at a stop (50 ms @ 50 MHz); bench overrides to 20
// PORTS
//  clock          in   1  system clock, 50 MHz
//  reset          in   1  synchronous, active-high; clears table, FSM, outputs
//  iniciar        in   1  level; scheduler leaves INICIAL while high
//  emergencia     in   1  level; forces motors off while high
//  sensoresNeg    in   4  active-low floor sensors, bit f = car at floor f
//  pedido_valido  in   1  request strobe from the serial decoder
//  pedido_dado    in   8  [1:0] origin, [3:2] dest, [5:4] obj, [7:6] ignored
//  pedido_pronto  out  1  table not full; transfer on pedido_valido & pedido_pronto
//  motorSubindo   out  1  drive up
//  motorDescendo  out  1  drive down
//  andarAtual     out  2  last floor seen by the sensors
//  proxParada     out  2  current target floor
//  porta_aberta   out  1  high during the dwell
//  entrega_valida out  1  1-cycle pulse per retired request
//  entrega_obj    out  2  obj of the retired request, valid with entrega_valida
//  fila_vazia     out  1  no valid slots
//  erro_sensor    out  1  sticky; more than one sensor low
// BEHAVIOUR
//  Reset values: all outputs 0 except pedido_pronto=1 and fila_vazia=1. Direction register = up.
//  Slot state: LIVRE -> AGUARDA (on accept) -> CARREGADO (pickup at origin) -> LIVRE (at dest).
//  Accept: takes the lowest LIVRE slot; written 1 cycle after the handshake.
//    pedido_pronto=0 when all slots are used.
//  Position: andarAtual updates when exactly one sensoresNeg bit is 0.
//    All ones means between floors: hold the value.
//    Two or more zeros: hold, set erro_sensor, go to EMERG.
//  Stop masks: coleta[f] = any AGUARDA slot with origin f; entrega[f] = any CARREGADO slot with dest f.
//    pend = coleta | entrega.
//  SCAN: if pend[andarAtual], the target is the current floor.
//    Otherwise take the nearest pend floor strictly ahead in the current direction.
//    If there is none, flip direction and take the nearest pend floor behind.
//    If pend is 0, stay idle.
//  FSM states: INICIAL, OCIOSO, AVALIA, MOVENDO, PORTA, EMERG.
//   INICIAL -> OCIOSO when iniciar=1.
//   OCIOSO -> AVALIA when pend != 0.
//   AVALIA (1 cycle) latches proxParada. Goes to PORTA if target == andarAtual, else MOVENDO.
//   MOVENDO: exactly one motor high (Subindo if proxParada > andarAtual).
//     Motors drop in the same cycle the sensor shows proxParada; then PORTA.
//   PORTA: porta_aberta=1 for T_PORTA cycles.
//     First cycle: every AGUARDA slot with origin == floor becomes CARREGADO.
//     Next cycles: CARREGADO slots with dest == floor retire one per cycle, lowest slot first,
//       each retirement with entrega_valida pulse. A request with origin == dest is retired in the same dwell.
//     At the end of the dwell -> AVALIA if pend != 0, else OCIOSO.
//   EMERG: entered from any state except INICIAL when emergencia=1 (takes priority over all transitions).
//     Motors 0 next cycle; the table is kept. On emergencia=0 and erro_sensor=0 -> AVALIA.
//  Motors are never both high; both are 0 outside MOVENDO.
//  A request accepted during PORTA at the current floor is not serviced in that dwell.
//    AVALIA re-selects the same floor and opens a new dwell.
//  iniciar=0 does not abort a trip; the FSM only checks it in INICIAL.
//  Reset mid-trip: motors 0 on the next edge; the table is cleared.
// STRUCTURE
//  Shared package/header smartcargo_defs: FSM state encodings, slot-state codes,
//    pedido_dado field offsets, LARG_ANDAR.
//  Sub-module seletor_proxima_parada: combinational SCAN (pend, andarAtual, dir -> alvo, novo_dir, tem_alvo).
//  The top level holds the slot table, position decode, FSM and dwell counter.
// TESTING (T_PORTA=20; sensor model: 1000 cycles all-ones between floors)
//  1 Car at floor 0, send 8'h1D (orig 1, dest 3, obj 1): up to 1, dwell, up to 3, dwell.
//    Expect one entrega_valida with entrega_obj=01, then OCIOSO and fila_vazia=1.
//  2 Car at floor 2 going up with 8'h1E pending (orig 2, dest 3) and 8'h01 arriving (orig 1, dest 0).
//    Expect stops in order 2,3,1,0.
//  3 Fill 16 requests: pedido_pronto=0 after the 16th; the 17th strobe is ignored.
//    After the first retirement, pedido_pronto returns to 1.
//  4 emergencia=1 mid-MOVENDO: motors 0 within 1 cycle, table kept.
//    Release: the trip resumes to the same proxParada.
//  5 sensoresNeg=4'b1100 while moving: erro_sensor=1, motors 0; stays in EMERG until reset.
//  6 Request 8'h05 (orig 1, dest 1) with car at 1: single dwell, one entrega pulse; reset mid-dwell clears all.

Source files
------------

// File: rtl/escalonador_paradas_pkg.sv
// Shared definitions for the cargo-elevator scheduler: FSM encodings, slot states,
// request field offsets and the slot record.
package smartcargo_defs;

    localparam int LARG_ANDAR = 2;

    localparam logic [2:0] ST_INICIAL = 3'd0;
    localparam logic [2:0] ST_OCIOSO  = 3'd1;
    localparam logic [2:0] ST_AVALIA  = 3'd2;
    localparam logic [2:0] ST_MOVENDO = 3'd3;
    localparam logic [2:0] ST_PORTA   = 3'd4;
    localparam logic [2:0] ST_EMERG   = 3'd5;

    localparam logic [1:0] SLOT_LIVRE     = 2'd0;
    localparam logic [1:0] SLOT_AGUARDA   = 2'd1;
    localparam logic [1:0] SLOT_CARREGADO = 2'd2;

    localparam int PD_ORIG_LSB = 0;
    localparam int PD_DEST_LSB = 2;
    localparam int PD_OBJ_LSB  = 4;

    typedef struct packed {
        logic [1:0]            estado;
        logic [LARG_ANDAR-1:0] orig;
        logic [LARG_ANDAR-1:0] dest;
        logic [1:0]            obj;
    } slot_t;

endpackage

// File: rtl/escalonador_paradas_seletor.sv
// Combinational SCAN stop selection: current floor first, then nearest ahead,
// otherwise reverse and take the nearest behind.
module seletor_proxima_parada #(
    parameter int N_ANDARES  = 4,
    parameter int LARG_ANDAR = 2
) (
    input  logic [N_ANDARES-1:0]  pend,
    input  logic [LARG_ANDAR-1:0] andar,
    input  logic                  dir,
    output logic [LARG_ANDAR-1:0] alvo,
    output logic                  novo_dir,
    output logic                  tem_alvo
);

    logic                  acima_ok;
    logic                  abaixo_ok;
    logic [LARG_ANDAR-1:0] acima;
    logic [LARG_ANDAR-1:0] abaixo;

    always_comb begin
        acima_ok  = 1'b0;
        abaixo_ok = 1'b0;
        acima     = '0;
        abaixo    = '0;
        // Downward scan leaves the smallest floor above; upward scan the largest below.
        for (int f = N_ANDARES - 1; f >= 0; f--) begin
            if (pend[f] && f > int'(andar)) begin
                acima_ok = 1'b1;
                acima    = LARG_ANDAR'(f);
            end
        end
        for (int f = 0; f < N_ANDARES; f++) begin
            if (pend[f] && f < int'(andar)) begin
                abaixo_ok = 1'b1;
                abaixo    = LARG_ANDAR'(f);
            end
        end
    end

    always_comb begin
        tem_alvo = |pend;
        alvo     = andar;
        novo_dir = dir;
        if (!pend[andar]) begin
            if (dir) begin
                if (acima_ok) begin
                    alvo = acima;
                end else if (abaixo_ok) begin
                    alvo     = abaixo;
                    novo_dir = 1'b0;
                end
            end else begin
                if (abaixo_ok) begin
                    alvo = abaixo;
                end else if (acima_ok) begin
                    alvo     = acima;
                    novo_dir = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/escalonador_paradas.sv
// Cargo-elevator stop scheduler: request table, car position tracking, SCAN FSM,
// motor drive, door dwell and per-object delivery pulses.
module escalonador_paradas #(
    parameter int N_ANDARES  = 4,
    parameter int LARG_ANDAR = smartcargo_defs::LARG_ANDAR,
    parameter int PROF_FILA  = 16,
    parameter int T_PORTA    = 2500000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iniciar,
    input  logic                  emergencia,
    input  logic [N_ANDARES-1:0]  sensoresNeg,
    input  logic                  pedido_valido,
    input  logic [7:0]            pedido_dado,
    output logic                  pedido_pronto,
    output logic                  motorSubindo,
    output logic                  motorDescendo,
    output logic [LARG_ANDAR-1:0] andarAtual,
    output logic [LARG_ANDAR-1:0] proxParada,
    output logic                  porta_aberta,
    output logic                  entrega_valida,
    output logic [1:0]            entrega_obj,
    output logic                  fila_vazia,
    output logic                  erro_sensor
);
    import smartcargo_defs::*;

    localparam int LARG_CNT = (T_PORTA > 1) ? $clog2(T_PORTA) : 1;
    localparam int LARG_NZ  = $clog2(N_ANDARES + 1);

    slot_t                 tab_q [PROF_FILA];
    slot_t                 tab_d [PROF_FILA];
    logic [2:0]            estado_q, estado_d;
    logic                  dir_q, dir_d;
    logic [LARG_ANDAR-1:0] andar_q, andar_d;
    logic [LARG_ANDAR-1:0] prox_q, prox_d;
    logic                  erro_q, erro_d;
    logic [LARG_CNT-1:0]   cnt_q, cnt_d;
    logic                  ent_vld_q, ent_vld_d;
    logic [1:0]            ent_obj_q, ent_obj_d;

    logic [LARG_NZ-1:0]    n_zeros;
    logic [LARG_ANDAR-1:0] sensor_idx;
    logic                  sensor_ok, sensor_multi, chegou;
    logic [N_ANDARES-1:0]  coleta, entrega, pend;
    logic                  algum_livre, todos_livres, aceita;
    logic                  achou_livre, achou_ret;
    logic [LARG_ANDAR-1:0] alvo;
    logic                  novo_dir, tem_alvo, em_mov;
    logic                  pedido_unused;

    assign pedido_unused = ^pedido_dado[7:6];

    // Floor sensors: exactly one low bit is a valid floor, all high is between floors.
    always_comb begin
        n_zeros    = '0;
        sensor_idx = '0;
        for (int f = 0; f < N_ANDARES; f++) begin
            if (!sensoresNeg[f]) begin
                n_zeros    = n_zeros + LARG_NZ'(1);
                sensor_idx = LARG_ANDAR'(f);
            end
        end
        sensor_ok    = (n_zeros == LARG_NZ'(1));
        sensor_multi = (n_zeros > LARG_NZ'(1));
        chegou       = sensor_ok && (sensor_idx == prox_q);
        andar_d      = sensor_ok ? sensor_idx : andar_q;
        erro_d       = erro_q | sensor_multi;
    end

    always_comb begin
        coleta       = '0;
        entrega      = '0;
        algum_livre  = 1'b0;
        todos_livres = 1'b1;
        for (int i = 0; i < PROF_FILA; i++) begin
            if (tab_q[i].estado == SLOT_AGUARDA)   coleta[tab_q[i].orig]  = 1'b1;
            if (tab_q[i].estado == SLOT_CARREGADO) entrega[tab_q[i].dest] = 1'b1;
            if (tab_q[i].estado == SLOT_LIVRE)     algum_livre  = 1'b1;
            else                                   todos_livres = 1'b0;
        end
        pend = coleta | entrega;
    end

    assign aceita = pedido_valido && algum_livre;

    // Accept, pickup and retirement always touch disjoint slots, so one pass suffices.
    always_comb begin
        tab_d       = tab_q;
        ent_vld_d   = 1'b0;
        ent_obj_d   = ent_obj_q;
        achou_livre = 1'b0;
        achou_ret   = 1'b0;
        for (int i = 0; i < PROF_FILA; i++) begin
            if (aceita && !achou_livre && tab_q[i].estado == SLOT_LIVRE) begin
                tab_d[i].estado = SLOT_AGUARDA;
                tab_d[i].orig   = pedido_dado[PD_ORIG_LSB +: LARG_ANDAR];
                tab_d[i].dest   = pedido_dado[PD_DEST_LSB +: LARG_ANDAR];
                tab_d[i].obj    = pedido_dado[PD_OBJ_LSB +: 2];
                achou_livre     = 1'b1;
            end
        end
        if (estado_q == ST_PORTA) begin
            for (int i = 0; i < PROF_FILA; i++) begin
                if (cnt_q == '0) begin
                    if (tab_q[i].estado == SLOT_AGUARDA && tab_q[i].orig == prox_q)
                        tab_d[i].estado = SLOT_CARREGADO;
                end else if (!achou_ret && tab_q[i].estado == SLOT_CARREGADO &&
                             tab_q[i].dest == prox_q) begin
                    tab_d[i].estado = SLOT_LIVRE;
                    ent_vld_d       = 1'b1;
                    ent_obj_d       = tab_q[i].obj;
                    achou_ret       = 1'b1;
                end
            end
        end
    end

    seletor_proxima_parada #(
        .N_ANDARES (N_ANDARES),
        .LARG_ANDAR(LARG_ANDAR)
    ) u_seletor (
        .pend    (pend),
        .andar   (andar_q),
        .dir     (dir_q),
        .alvo    (alvo),
        .novo_dir(novo_dir),
        .tem_alvo(tem_alvo)
    );

    always_comb begin
        estado_d = estado_q;
        dir_d    = dir_q;
        prox_d   = prox_q;
        cnt_d    = cnt_q;
        case (estado_q)
            ST_INICIAL: if (iniciar) estado_d = ST_OCIOSO;
            ST_OCIOSO:  if (pend != '0) estado_d = ST_AVALIA;
            ST_AVALIA: begin
                if (tem_alvo) begin
                    prox_d   = alvo;
                    dir_d    = novo_dir;
                    cnt_d    = '0;
                    estado_d = (alvo == andar_q && sensor_ok) ? ST_PORTA : ST_MOVENDO;
                end else begin
                    estado_d = ST_OCIOSO;
                end
            end
            ST_MOVENDO: begin
                if (chegou) begin
                    estado_d = ST_PORTA;
                    cnt_d    = '0;
                end
            end
            ST_PORTA: begin
                if (cnt_q == LARG_CNT'(T_PORTA - 1))
                    estado_d = (pend != '0) ? ST_AVALIA : ST_OCIOSO;
                else
                    cnt_d = cnt_q + LARG_CNT'(1);
            end
            ST_EMERG:   if (!emergencia && !erro_q) estado_d = ST_AVALIA;
            default:    estado_d = ST_INICIAL;
        endcase
        // A latched sensor fault keeps the car parked until reset.
        if (estado_q != ST_INICIAL && (emergencia || sensor_multi || erro_q))
            estado_d = ST_EMERG;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= ST_INICIAL;
            dir_q     <= 1'b1;
            andar_q   <= '0;
            prox_q    <= '0;
            erro_q    <= 1'b0;
            cnt_q     <= '0;
            ent_vld_q <= 1'b0;
            ent_obj_q <= '0;
            for (int i = 0; i < PROF_FILA; i++) tab_q[i] <= '0;
        end else begin
            estado_q  <= estado_d;
            dir_q     <= dir_d;
            andar_q   <= andar_d;
            prox_q    <= prox_d;
            erro_q    <= erro_d;
            cnt_q     <= cnt_d;
            ent_vld_q <= ent_vld_d;
            ent_obj_q <= ent_obj_d;
            for (int i = 0; i < PROF_FILA; i++) tab_q[i] <= tab_d[i];
        end
    end

    // Motors cut combinationally on the arrival cycle.
    assign em_mov         = (estado_q == ST_MOVENDO) && !chegou;
    assign motorSubindo   = em_mov && (prox_q > andar_q);
    assign motorDescendo  = em_mov && !(prox_q > andar_q);
    assign pedido_pronto  = algum_livre;
    assign fila_vazia     = todos_livres;
    assign andarAtual     = andar_q;
    assign proxParada     = prox_q;
    assign porta_aberta   = (estado_q == ST_PORTA);
    assign entrega_valida = ent_vld_q;
    assign entrega_obj    = ent_obj_q;
    assign erro_sensor    = erro_q;

endmodule

// File: tb/tb_escalonador_paradas.sv
// Bench for escalonador_paradas: floor-sensor car model plus stop/delivery scoreboard.
module tb_escalonador_paradas;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       emergencia = 1'b0;
    logic [3:0] sensoresNeg = 4'b1110;
    logic       pedido_valido = 1'b0;
    logic [7:0] pedido_dado = 8'h00;
    logic       pedido_pronto, motorSubindo, motorDescendo;
    logic [1:0] andarAtual, proxParada;
    logic       porta_aberta, entrega_valida;
    logic [1:0] entrega_obj;
    logic       fila_vazia, erro_sensor;

    int errors = 0;
    int checks = 0;
    int exp_stops[$];
    int exp_objs[$];

    int pos = 0;
    int trav = 0;
    bit em_transito = 0;
    bit sub = 0;
    bit sens_override = 0;
    bit prev_porta = 0;

    escalonador_paradas #(
        .N_ANDARES(4), .LARG_ANDAR(2), .PROF_FILA(16), .T_PORTA(20)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .emergencia(emergencia),
        .sensoresNeg(sensoresNeg), .pedido_valido(pedido_valido), .pedido_dado(pedido_dado),
        .pedido_pronto(pedido_pronto), .motorSubindo(motorSubindo), .motorDescendo(motorDescendo),
        .andarAtual(andarAtual), .proxParada(proxParada), .porta_aberta(porta_aberta),
        .entrega_valida(entrega_valida), .entrega_obj(entrega_obj), .fila_vazia(fila_vazia),
        .erro_sensor(erro_sensor)
    );

    initial forever #10 clock = ~clock;

    // Car model: 1000 cycles of all-ones between adjacent floors while a motor runs.
    initial forever begin
        @(negedge clock);
        if (!sens_override && (motorSubindo || motorDescendo)) begin
            if (!em_transito) begin
                em_transito = 1;
                sub         = motorSubindo;
                trav        = 0;
                sensoresNeg = 4'b1111;
            end else begin
                trav++;
                if (trav >= 1000) begin
                    pos         = sub ? pos + 1 : pos - 1;
                    em_transito = 0;
                    sensoresNeg = ~(4'b0001 << pos);
                end
            end
        end
    end

    // Scoreboard: each dwell opening and each delivery pulse pops its expectation.
    initial forever begin
        int e;
        @(negedge clock);
        if (porta_aberta === 1'b1 && !prev_porta) begin
            checks++;
            if (exp_stops.size() == 0) begin
                errors++;
                $display("FAIL stop: unexpected dwell at floor %0d", andarAtual);
            end else begin
                e = exp_stops.pop_front();
                if (int'(andarAtual) !== e) begin
                    errors++;
                    $display("FAIL stop: floor %0d, expected %0d", andarAtual, e);
                end
            end
        end
        prev_porta = (porta_aberta === 1'b1);
        if (entrega_valida === 1'b1) begin
            checks++;
            if (exp_objs.size() == 0) begin
                errors++;
                $display("FAIL entrega: unexpected pulse obj %0d", entrega_obj);
            end else begin
                e = exp_objs.pop_front();
                if (int'(entrega_obj) !== e) begin
                    errors++;
                    $display("FAIL entrega: obj %0d, expected %0d", entrega_obj, e);
                end
            end
        end
        if (motorSubindo === 1'b1 || motorDescendo === 1'b1) begin
            checks++;
            if (motorSubindo && motorDescendo) begin
                errors++;
                $display("FAIL motores: both motors high");
            end
        end
    end

    task automatic do_reset(input int p);
        reset         = 1'b1;
        pedido_valido = 1'b0;
        emergencia    = 1'b0;
        sens_override = 0;
        em_transito   = 0;
        pos           = p;
        sensoresNeg   = ~(4'b0001 << p);
        repeat (3) @(negedge clock);
        reset   = 1'b0;
        iniciar = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        pedido_dado   = d;
        pedido_valido = 1'b1;
        @(negedge clock);
        pedido_valido = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int n = 0;
        while (!(fila_vazia && !porta_aberta && !motorSubindo && !motorDescendo &&
                 exp_stops.size() == 0 && exp_objs.size() == 0) && n < maxc) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL %s: not idle after %0d cycles, stops left %0d objs left %0d",
                     nm, n, exp_stops.size(), exp_objs.size());
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        iniciar     = 1'b0;
        sensoresNeg = 4'b1011;
        repeat (2) @(negedge clock);
        if (pedido_pronto !== 1'b1) begin errors++; $display("FAIL reset_pronto: got %b want 1", pedido_pronto); end
        checks++;
        if (fila_vazia !== 1'b1) begin errors++; $display("FAIL reset_vazia: got %b want 1", fila_vazia); end
        checks++;
        if ({motorSubindo, motorDescendo, porta_aberta, entrega_valida, erro_sensor} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {motorSubindo, motorDescendo, porta_aberta, entrega_valida, erro_sensor});
        end
        checks++;
        if ({andarAtual, proxParada, entrega_obj} !== 6'b0) begin
            errors++; $display("FAIL reset_campos: got %b want 000000", {andarAtual, proxParada, entrega_obj});
        end
        checks++;
        // With iniciar low the FSM must sit in INICIAL even with work queued.
        reset = 1'b0;
        send(8'h00);
        repeat (10) @(negedge clock);
        if (porta_aberta !== 1'b0 || fila_vazia !== 1'b0) begin
            errors++; $display("FAIL inicial_espera: porta %b vazia %b want 0 0", porta_aberta, fila_vazia);
        end
        checks++;
        if (andarAtual !== 2'd2) begin errors++; $display("FAIL inicial_andar: got %0d want 2", andarAtual); end
        checks++;
    endtask

    task automatic test_viagem();
        do_reset(0);
        exp_stops.push_back(1); exp_stops.push_back(3);
        exp_objs.push_back(1);
        send(8'h1D);
        wait_idle("viagem", 6000);
        repeat (5) @(negedge clock);
        if (fila_vazia !== 1'b1 || porta_aberta !== 1'b0 || andarAtual !== 2'd3) begin
            errors++;
            $display("FAIL viagem_fim: vazia %b porta %b andar %0d want 1 0 3", fila_vazia, porta_aberta, andarAtual);
        end
        checks++;
    endtask

    task automatic test_scan();
        do_reset(2);
        exp_stops.push_back(2); exp_stops.push_back(3);
        exp_stops.push_back(1); exp_stops.push_back(0);
        exp_objs.push_back(1); exp_objs.push_back(0);
        send(8'h1E);
        send(8'h01);
        wait_idle("scan", 10000);
        if (andarAtual !== 2'd0) begin errors++; $display("FAIL scan_fim: andar %0d want 0", andarAtual); end
        checks++;
    endtask

    task automatic test_fila_cheia();
        int n = 0;
        do_reset(0);
        exp_stops.push_back(3); exp_stops.push_back(0);
        for (int i = 0; i < 16; i++) begin
            logic [1:0] ob;
            ob = 2'(i % 4);
            exp_objs.push_back(i % 4);
            send({2'b00, ob, 2'b00, 2'b11});
        end
        if (pedido_pronto !== 1'b0) begin errors++; $display("FAIL cheia_pronto: got %b want 0", pedido_pronto); end
        checks++;
        send(8'h07);  // would add a stop at floor 1 if it were taken
        if (pedido_pronto !== 1'b0) begin errors++; $display("FAIL cheia_17: got %b want 0", pedido_pronto); end
        checks++;
        while (entrega_valida !== 1'b1 && n < 8000) begin @(negedge clock); n++; end
        checks++;
        if (n >= 8000) begin
            errors++; $display("FAIL cheia_espera: no delivery within %0d cycles", n);
        end else if (pedido_pronto !== 1'b1) begin
            errors++; $display("FAIL cheia_libera: pronto %b want 1", pedido_pronto);
        end
        wait_idle("cheia", 8000);
    endtask

    task automatic test_emergencia();
        int n = 0;
        do_reset(0);
        exp_stops.push_back(2);
        exp_objs.push_back(0);
        send(8'h0A);
        while (motorSubindo !== 1'b1 && n < 100) begin @(negedge clock); n++; end
        repeat (1500) @(negedge clock);
        emergencia = 1'b1;
        @(negedge clock);
        if (motorSubindo !== 1'b0 || motorDescendo !== 1'b0) begin
            errors++; $display("FAIL emerg_motor: up %b down %b want 0 0", motorSubindo, motorDescendo);
        end
        checks++;
        repeat (50) @(negedge clock);
        if (motorSubindo !== 1'b0 || fila_vazia !== 1'b0 || proxParada !== 2'd2 || sensoresNeg !== 4'b1111) begin
            errors++;
            $display("FAIL emerg_hold: up %b vazia %b prox %0d sens %b want 0 0 2 1111",
                     motorSubindo, fila_vazia, proxParada, sensoresNeg);
        end
        checks++;
        emergencia = 1'b0;
        n = 0;
        while (motorSubindo !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        if (n >= 20 || proxParada !== 2'd2) begin
            errors++; $display("FAIL emerg_retoma: wait %0d prox %0d want <20 2", n, proxParada);
        end
        checks++;
        wait_idle("emerg", 3000);
    endtask

    task automatic test_erro_sensor();
        int n = 0;
        do_reset(0);
        send(8'h0F);
        while (motorSubindo !== 1'b1 && n < 100) begin @(negedge clock); n++; end
        repeat (200) @(negedge clock);
        sens_override = 1;
        sensoresNeg   = 4'b1100;
        @(negedge clock);
        if (erro_sensor !== 1'b1 || motorSubindo !== 1'b0 || motorDescendo !== 1'b0) begin
            errors++; $display("FAIL sensor_erro: erro %b up %b down %b want 1 0 0", erro_sensor, motorSubindo, motorDescendo);
        end
        checks++;
        sensoresNeg = 4'b1111;
        repeat (100) @(negedge clock);
        if (erro_sensor !== 1'b1 || motorSubindo !== 1'b0 || porta_aberta !== 1'b0 || fila_vazia !== 1'b0) begin
            errors++;
            $display("FAIL sensor_preso: erro %b up %b porta %b vazia %b want 1 0 0 0",
                     erro_sensor, motorSubindo, porta_aberta, fila_vazia);
        end
        checks++;
        do_reset(0);
        @(negedge clock);
        if (erro_sensor !== 1'b0 || fila_vazia !== 1'b1) begin
            errors++; $display("FAIL sensor_reset: erro %b vazia %b want 0 1", erro_sensor, fila_vazia);
        end
        checks++;
    endtask

    task automatic test_mesmo_andar();
        int n = 0;
        do_reset(1);
        exp_stops.push_back(1);
        exp_objs.push_back(0);
        send(8'h05);
        wait_idle("mesmo", 200);
        if (andarAtual !== 2'd1) begin errors++; $display("FAIL mesmo_andar: got %0d want 1", andarAtual); end
        checks++;
        exp_stops.push_back(1);
        send(8'h05);
        while (porta_aberta !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        if (porta_aberta !== 1'b0 || fila_vazia !== 1'b1 || pedido_pronto !== 1'b1 || entrega_valida !== 1'b0) begin
            errors++;
            $display("FAIL mesmo_reset: porta %b vazia %b pronto %b ent %b want 0 1 1 0",
                     porta_aberta, fila_vazia, pedido_pronto, entrega_valida);
        end
        checks++;
        repeat (30) @(negedge clock);
        if (exp_stops.size() != 0 || exp_objs.size() != 0 || porta_aberta !== 1'b0) begin
            errors++;
            $display("FAIL mesmo_limpo: stops %0d objs %0d porta %b want 0 0 0",
                     exp_stops.size(), exp_objs.size(), porta_aberta);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_viagem();
        test_scan();
        test_fila_cheia();
        test_emergencia();
        test_erro_sensor();
        test_mesmo_andar();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
